// File: rtl/hc86_xor_arbiter_if.sv
// hc86_xor_arbiter_if
//   Groups the requester, shared XOR gate and result-consumer signals of
//   hc86_xor_arbiter.
//   slave  : arbiter side. It takes req/a_in/b_in/xy/res_rdy/clr_err and
//            drives gnt/xa/xb/res/res_id/res_vld/err.
//   master : environment side, with the directions mirrored.
//   Parameters: NREQ requesters, W-bit operands, IDW-bit requester index.
interface hc86_xor_arbiter_if #(
   parameter int NREQ = 4,
   parameter int W    = 4,
   parameter int IDW  = 2
);
   logic [NREQ-1:0]   req;
   logic [NREQ*W-1:0] a_in;
   logic [NREQ*W-1:0] b_in;
   logic [NREQ-1:0]   gnt;
   logic [W-1:0]      xa;
   logic [W-1:0]      xb;
   logic [W-1:0]      xy;
   logic [W-1:0]      res;
   logic [IDW-1:0]    res_id;
   logic              res_vld;
   logic              res_rdy;
   logic              clr_err;
   logic              err;

   modport slave (
      input  req, a_in, b_in, xy, res_rdy, clr_err,
      output gnt, xa, xb, res, res_id, res_vld, err
   );

   modport master (
      output req, a_in, b_in, xy, res_rdy, clr_err,
      input  gnt, xa, xb, res, res_id, res_vld, err
   );
endinterface

// File: rtl/hc86_xor_arbiter.sv
// hc86_xor_arbiter
//   Round-robin sequencer that shares one external W-bit XOR gate (HC86)
//   among NREQ requesters. The granted operand pair is registered onto xa/xb.
//   The gate output xy is captured one cycle later into res, together with the
//   owning requester index. The captured value is also checked against an
//   internal XOR, and any disagreement sets the sticky err flag.
// Ports
//   clk       : single clock, rising edge
//   rst_n     : asynchronous active-low reset
//   bus       : hc86_xor_arbiter_if.slave (requests, gate, result, error)
//   dbg_state : current FSM state (0 IDLE, 1 ISSUE, 2 HOLD)
// Result handshake: res/res_id are valid while res_vld=1. They hold steady
//   until the cycle in which res_vld and res_rdy are both high. A result is
//   consumed on that edge, and never otherwise.
module hc86_xor_arbiter #(
   parameter int NREQ = 4,
   parameter int W    = 4,
   parameter int IDW  = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   hc86_xor_arbiter_if.slave      bus,
   output logic [1:0]             dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_HOLD  = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [IDW-1:0]  ptr_q, ptr_d;
   logic [IDW-1:0]  id_q, id_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [W-1:0]    xa_q, xa_d;
   logic [W-1:0]    xb_q, xb_d;
   logic [W-1:0]    res_q, res_d;
   logic [IDW-1:0]  res_id_q, res_id_d;
   logic            res_vld_q, res_vld_d;
   logic            err_q, err_d;

   logic            arb_any;
   logic            arb_go;
   logic [IDW-1:0]  arb_sel;
   logic [IDW-1:0]  arb_nxt;

   // Round-robin pick: scan ptr, ptr+1, ... wrapping at NREQ.
   // The first requester found wins.
   always_comb begin
      int  idx;
      logic found;
      idx     = 0;
      found   = 1'b0;
      arb_sel = '0;
      arb_any = |bus.req;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && bus.req[idx]) begin
            found   = 1'b1;
            arb_sel = IDW'(idx);
         end
      end
      if (int'(arb_sel) == NREQ - 1) arb_nxt = '0;
      else                           arb_nxt = arb_sel + 1'b1;
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      id_d      = id_q;
      gnt_d     = '0;          // grant is a single-cycle pulse
      xa_d      = xa_q;
      xb_d      = xb_q;
      res_d     = res_q;
      res_id_d  = res_id_q;
      res_vld_d = res_vld_q;
      err_d     = err_q;
      arb_go    = 1'b0;

      if (bus.clr_err) err_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (arb_any) arb_go = 1'b1;
         end
         ST_ISSUE: begin
            res_d     = bus.xy;
            res_id_d  = id_q;
            res_vld_d = 1'b1;
            // A mismatch overrides a clear requested in the same cycle.
            if (bus.xy != (xa_q ^ xb_q)) err_d = 1'b1;
            state_d   = ST_HOLD;
         end
         ST_HOLD: begin
            if (res_vld_q && bus.res_rdy) begin
               res_vld_d = 1'b0;
               // Issue back-to-back in the consume cycle to sustain 1 op / 2 cycles.
               if (arb_any) arb_go = 1'b1;
               else         state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (arb_go) begin
         gnt_d[arb_sel] = 1'b1;
         xa_d           = bus.a_in[arb_sel*W +: W];
         xb_d           = bus.b_in[arb_sel*W +: W];
         id_d           = arb_sel;
         ptr_d          = arb_nxt;
         state_d        = ST_ISSUE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         id_q      <= '0;
         gnt_q     <= '0;
         xa_q      <= '0;
         xb_q      <= '0;
         res_q     <= '0;
         res_id_q  <= '0;
         res_vld_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         id_q      <= id_d;
         gnt_q     <= gnt_d;
         xa_q      <= xa_d;
         xb_q      <= xb_d;
         res_q     <= res_d;
         res_id_q  <= res_id_d;
         res_vld_q <= res_vld_d;
         err_q     <= err_d;
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.xa      = xa_q;
   assign bus.xb      = xb_q;
   assign bus.res     = res_q;
   assign bus.res_id  = res_id_q;
   assign bus.res_vld = res_vld_q;
   assign bus.err     = err_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_hc86_xor_arbiter.sv
// tb_hc86_xor_arbiter
//   Directed bench for hc86_xor_arbiter. It builds one 4-requester, 4-bit
//   instance and one 1-requester, 8-bit instance. The shared gate is modelled
//   as xa^xb, with an optional fault mask XORed in.
module tb_hc86_xor_arbiter;

   logic clk;
   logic rst_n;
   logic [3:0] fault_mask;
   logic [1:0] dbg4;
   logic [1:0] dbg1;

   int n_checks = 0;
   int n_errors = 0;

   logic [3:0] exp_q[$];

   hc86_xor_arbiter_if #(.NREQ(4), .W(4), .IDW(2)) bus4 ();
   hc86_xor_arbiter_if #(.NREQ(1), .W(8), .IDW(1)) bus1 ();

   hc86_xor_arbiter #(.NREQ(4), .W(4), .IDW(2)) u_dut4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus4.slave),
      .dbg_state (dbg4)
   );

   hc86_xor_arbiter #(.NREQ(1), .W(8), .IDW(1)) u_dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus1.slave),
      .dbg_state (dbg1)
   );

   // External HC86 gate models
   assign bus4.xy = bus4.xa ^ bus4.xb ^ fault_mask;
   assign bus1.xy = bus1.xa ^ bus1.xb;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
      $fatal(1, "timeout");
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   logic [3:0] exp_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
   logic [3:0] exp_res [5] = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE};
   logic [1:0] exp_id  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

   initial begin
      logic [3:0] r;
      rst_n        = 1'b1;
      fault_mask   = 4'h0;
      bus4.req     = '0;
      bus4.a_in    = '0;
      bus4.b_in    = '0;
      bus4.res_rdy = 1'b0;
      bus4.clr_err = 1'b0;
      bus1.req     = '0;
      bus1.a_in    = '0;
      bus1.b_in    = '0;
      bus1.res_rdy = 1'b0;
      bus1.clr_err = 1'b0;

      // ---- reset values ----
      #2 rst_n = 1'b0;
      #1;
      check("rst_gnt",   32'(bus4.gnt), 0);
      check("rst_xa",    32'(bus4.xa), 0);
      check("rst_xb",    32'(bus4.xb), 0);
      check("rst_res",   32'(bus4.res), 0);
      check("rst_id",    32'(bus4.res_id), 0);
      check("rst_vld",   32'(bus4.res_vld), 0);
      check("rst_err",   32'(bus4.err), 0);
      check("rst_state", 32'(dbg4), 0);
      tick();
      tick();
      rst_n = 1'b1;

      // ---- single request ----
      bus4.req  = 4'b0001;
      bus4.a_in = 16'h000A;
      bus4.b_in = 16'h0006;
      tick();
      check("t1_gnt", 32'(bus4.gnt), 32'b0001);
      check("t1_xa",  32'(bus4.xa), 32'hA);
      check("t1_xb",  32'(bus4.xb), 32'h6);
      check("t1_vld0", 32'(bus4.res_vld), 0);
      bus4.req = 4'b0000;
      tick();
      check("t1_res",  32'(bus4.res), 32'hC);
      check("t1_id",   32'(bus4.res_id), 0);
      check("t1_vld",  32'(bus4.res_vld), 1);
      check("t1_gnt0", 32'(bus4.gnt), 0);
      bus4.res_rdy = 1'b1;
      tick();
      check("t1_vld_done", 32'(bus4.res_vld), 0);
      check("t1_idle",     32'(dbg4), 0);

      // ---- fairness, all requesting (pointer restarts at 0) ----
      do_reset();
      bus4.a_in    = 16'h8421;
      bus4.b_in    = 16'hFFFF;
      bus4.res_rdy = 1'b1;
      bus4.req     = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("fair_gnt", 32'(bus4.gnt), 32'(exp_gnt[k]));
         check("fair_vld0", 32'(bus4.res_vld), 0);
         exp_q.push_back(exp_res[k]);
         tick();
         check("fair_gnt0", 32'(bus4.gnt), 0);
         check("fair_vld1", 32'(bus4.res_vld), 1);
         r = exp_q.pop_front();
         check("fair_res", 32'(bus4.res), 32'(r));
         check("fair_id",  32'(bus4.res_id), 32'(exp_id[k]));
      end

      // ---- backpressure: result for requester 0 held ----
      bus4.res_rdy = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("bp_vld", 32'(bus4.res_vld), 1);
         check("bp_res", 32'(bus4.res), 32'hE);
         check("bp_id",  32'(bus4.res_id), 0);
         check("bp_gnt", 32'(bus4.gnt), 0);
      end
      bus4.res_rdy = 1'b1;
      tick();
      check("bp_gnt_next", 32'(bus4.gnt), 32'b0010);
      check("bp_vld_drop", 32'(bus4.res_vld), 0);
      tick();
      check("bp_res_next", 32'(bus4.res), 32'hD);
      check("bp_id_next",  32'(bus4.res_id), 1);
      bus4.req = 4'b0000;
      tick();
      check("bp_idle", 32'(dbg4), 0);

      // ---- fault injection ----
      bus4.req   = 4'b0001;
      bus4.a_in  = 16'h0003;
      bus4.b_in  = 16'h0005;
      fault_mask = 4'h1;
      tick();
      bus4.req = 4'b0000;
      tick();
      check("flt_res", 32'(bus4.res), 32'h7);
      check("flt_err", 32'(bus4.err), 1);
      fault_mask = 4'h0;
      tick();
      check("flt_sticky1", 32'(bus4.err), 1);
      tick();
      check("flt_sticky2", 32'(bus4.err), 1);
      bus4.clr_err = 1'b1;
      tick();
      bus4.clr_err = 1'b0;
      check("flt_clr", 32'(bus4.err), 0);
      bus4.req   = 4'b0001;
      fault_mask = 4'h1;
      tick();
      bus4.req     = 4'b0000;
      bus4.clr_err = 1'b1;
      tick();
      check("flt_set_wins", 32'(bus4.err), 1);
      bus4.clr_err = 1'b0;
      fault_mask   = 4'h0;
      tick();
      check("flt_sticky3", 32'(bus4.err), 1);
      bus4.clr_err = 1'b1;
      tick();
      bus4.clr_err = 1'b0;
      check("flt_clr2", 32'(bus4.err), 0);
      bus4.req = 4'b0001;
      tick();
      bus4.req = 4'b0000;
      tick();
      check("good_res", 32'(bus4.res), 32'h6);
      check("good_err", 32'(bus4.err), 0);
      tick();

      // ---- reset during ISSUE and HOLD ----
      bus4.res_rdy = 1'b0;
      bus4.req     = 4'b0001;
      tick();
      check("rsti_gnt1", 32'(bus4.gnt), 32'b0001);
      rst_n = 1'b0;
      #1;
      check("rsti_gnt0",  32'(bus4.gnt), 0);
      check("rsti_state", 32'(dbg4), 0);
      tick();
      rst_n = 1'b1;
      tick();
      bus4.req = 4'b0000;
      tick();
      tick();
      check("rsth_vld1", 32'(bus4.res_vld), 1);
      #2 rst_n = 1'b0;
      #1;
      check("rsth_vld0", 32'(bus4.res_vld), 0);
      check("rsth_gnt0", 32'(bus4.gnt), 0);
      check("rsth_res0", 32'(bus4.res), 0);
      tick();
      rst_n = 1'b1;
      bus4.a_in    = 16'h0000;
      bus4.b_in    = 16'h9050;
      bus4.res_rdy = 1'b1;
      bus4.req     = 4'b1010;
      tick();
      check("rsth_gnt_a", 32'(bus4.gnt), 32'b0010);
      tick();
      check("rsth_id_a",  32'(bus4.res_id), 1);
      check("rsth_res_a", 32'(bus4.res), 32'h5);
      tick();
      check("rsth_gnt_b", 32'(bus4.gnt), 32'b1000);
      tick();
      check("rsth_id_b",  32'(bus4.res_id), 3);
      check("rsth_res_b", 32'(bus4.res), 32'h9);
      bus4.req = 4'b0000;
      tick();

      // ---- single requester, 8-bit ----
      bus1.a_in    = 8'hFF;
      bus1.b_in    = 8'h0F;
      bus1.res_rdy = 1'b1;
      bus1.req     = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("n1_gnt", 32'(bus1.gnt), 1);
         check("n1_xa",  32'(bus1.xa), 32'hFF);
         check("n1_vld0", 32'(bus1.res_vld), 0);
         tick();
         check("n1_vld", 32'(bus1.res_vld), 1);
         check("n1_res", 32'(bus1.res), 32'hF0);
         check("n1_id",  32'(bus1.res_id), 0);
      end
      bus1.req = 1'b0;
      tick();
      check("n1_idle", 32'(dbg1), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
